// File: rtl/matrix_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_load_ctrl_pkg
// Purpose  : Shared types and defaults for the matrix operand load controller.
//            Holds the controller state encoding, the default geometry of one
//            matrix job and a helper for sizing byte pointers.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_load_ctrl_pkg;

    localparam int unsigned C_DEF_DATA_W           = 8;
    localparam int unsigned C_DEF_BYTES_PER_MATRIX = 32;
    localparam int unsigned C_DEF_NUM_MATRIX       = 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_START    = 3'd2,
        S_BURST    = 3'd3,
        S_WAIT_FIN = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    // Width needed to address n entries; never collapses to zero bits.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned C_DEF_PTR_W = ptr_w(C_DEF_BYTES_PER_MATRIX);

endpackage : matrix_load_ctrl_pkg
`default_nettype wire

// File: rtl/mlc_byte_buf.sv
`default_nettype none
// ============================================================================
// Module   : mlc_byte_buf
// Purpose  : One-matrix operand store. DEPTH x DATA_W registers with a single
//            synchronous write port and an asynchronous read port.
// Ports    : clk        - system clock
//            we         - write enable
//            waddr      - write address
//            wdata      - write data
//            raddr      - read address
//            rdata      - read data (combinational from raddr)
// Revision : 1.0 - initial release
// ============================================================================
module mlc_byte_buf
    import matrix_load_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = C_DEF_DATA_W,
    parameter int unsigned DEPTH  = C_DEF_BYTES_PER_MATRIX,
    parameter int unsigned AW     = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : mlc_byte_buf
`default_nettype wire

// File: rtl/matrix_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matrix_load_ctrl
// Purpose  : Buffers one matrix from a bursty byte source, pulses the
//            accelerator start, streams the matrix as a gap-free burst and
//            waits for finish, NUM_MATRIX times per job. The next matrix is
//            prefetched while the accelerator computes.
// Ports    : clk, rst (sync, active-high)
//            go / busy / done / error          - job control and status
//            src_valid / src_data / src_ready  - byte source handshake
//            acc_start_in / acc_valid_input / acc_x_load / acc_finish
//                                              - accelerator interface
//            matrix_idx                        - matrix currently in flight
// Options  : MATRIX_LOAD_CTRL_TIMEOUT_EN enables the finish watchdog; when it
//            expires error is set, done is skipped and the job is dropped.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_load_ctrl
    import matrix_load_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W           = C_DEF_DATA_W,
    parameter int unsigned BYTES_PER_MATRIX = C_DEF_BYTES_PER_MATRIX,
    parameter int unsigned NUM_MATRIX       = C_DEF_NUM_MATRIX,
    parameter int unsigned TIMEOUT_CYC      = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          go,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    input  logic                          src_valid,
    input  logic [DATA_W-1:0]             src_data,
    output logic                          src_ready,
    output logic                          acc_start_in,
    output logic                          acc_valid_input,
    output logic [DATA_W-1:0]             acc_x_load,
    input  logic                          acc_finish,
    output logic [$clog2(NUM_MATRIX):0]   matrix_idx
);

    localparam int unsigned c_ptr_w = ptr_w(BYTES_PER_MATRIX);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;
    localparam int unsigned c_idx_w = $clog2(NUM_MATRIX) + 1;

    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(BYTES_PER_MATRIX);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(BYTES_PER_MATRIX - 1);
    localparam logic [c_idx_w-1:0] c_last_mat = c_idx_w'(NUM_MATRIX - 1);

    localparam logic [2:0] c_st_idle     = S_IDLE;
    localparam logic [2:0] c_st_fill     = S_FILL;
    localparam logic [2:0] c_st_start    = S_START;
    localparam logic [2:0] c_st_burst    = S_BURST;
    localparam logic [2:0] c_st_wait_fin = S_WAIT_FIN;
    localparam logic [2:0] c_st_done     = S_DONE;

    generate
        if ((BYTES_PER_MATRIX == 0) ||
            ((BYTES_PER_MATRIX & (BYTES_PER_MATRIX - 1)) != 0) ||
            (NUM_MATRIX < 1) || (TIMEOUT_CYC < 1)) begin : g_bad_params
            $error("matrix_load_ctrl: illegal parameter set");
        end
    endgenerate

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_fill_cnt;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_idx_w-1:0] r_matrix_idx;

    logic               w_src_ready;
    logic               w_xfer;
    logic [c_cnt_w-1:0] w_fill_next;
    logic [DATA_W-1:0]  w_rdata;

    // Ready depends only on registered state, keeping src_valid off any
    // path to an output. Prefetch is allowed only if another matrix follows.
    always_comb begin
        w_src_ready = 1'b0;
        if (r_fill_cnt < c_full) begin
            if (r_state == c_st_fill) begin
                w_src_ready = 1'b1;
            end else if ((r_state == c_st_wait_fin) && (r_matrix_idx < c_last_mat)) begin
                w_src_ready = 1'b1;
            end
        end
    end

    assign w_xfer      = src_valid && w_src_ready;
    // Fill count including this cycle's byte; finish decisions use it so a
    // byte landing together with finish is already counted.
    assign w_fill_next = r_fill_cnt + c_cnt_w'(w_xfer);

    mlc_byte_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BYTES_PER_MATRIX),
        .AW     (c_ptr_w)
    ) u_buf (
        .clk    (clk),
        .we     (w_xfer),
        .waddr  (r_fill_cnt[c_ptr_w-1:0]),
        .wdata  (src_data),
        .raddr  (r_rd_ptr),
        .rdata  (w_rdata)
    );

`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
    localparam int unsigned        c_wd_w    = ptr_w(TIMEOUT_CYC);
    localparam logic [c_wd_w-1:0]  c_wd_last = c_wd_w'(TIMEOUT_CYC - 1);
    logic [c_wd_w-1:0] r_wd_cnt;
    logic              r_error;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_fill_cnt   <= '0;
            r_rd_ptr     <= '0;
            r_matrix_idx <= '0;
`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
            r_wd_cnt     <= '0;
            r_error      <= 1'b0;
`endif
        end else begin
            if (w_xfer) begin
                r_fill_cnt <= w_fill_next;
            end
            case (r_state)
                c_st_idle: begin
                    if (go) begin
                        r_state      <= c_st_fill;
                        r_fill_cnt   <= '0;
                        r_rd_ptr     <= '0;
                        r_matrix_idx <= '0;
`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
                        r_error      <= 1'b0;
`endif
                    end
                end
                c_st_fill: begin
                    if (w_xfer && (w_fill_next == c_full)) begin
                        r_state <= c_st_start;
                    end
                end
                c_st_start: begin
                    r_state <= c_st_burst;
                end
                c_st_burst: begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    if (r_rd_ptr == c_last_ptr) begin
                        // Buffer is free again: prefetch of the next matrix
                        // restarts from entry 0.
                        r_state    <= c_st_wait_fin;
                        r_fill_cnt <= '0;
                        r_rd_ptr   <= '0;
`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
                        r_wd_cnt   <= '0;
`endif
                    end
                end
                c_st_wait_fin: begin
                    if (acc_finish) begin
                        if (r_matrix_idx == c_last_mat) begin
                            r_state <= c_st_done;
                        end else begin
                            r_matrix_idx <= r_matrix_idx + 1'b1;
                            r_state      <= (w_fill_next == c_full) ? c_st_start : c_st_fill;
                        end
`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
                    end else if (r_wd_cnt == c_wd_last) begin
                        r_error      <= 1'b1;
                        r_state      <= c_st_idle;
                        r_matrix_idx <= '0;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
`endif
                    end
                end
                c_st_done: begin
                    r_state      <= c_st_idle;
                    r_matrix_idx <= '0;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    assign busy            = (r_state != c_st_idle);
    assign done            = (r_state == c_st_done);
    assign src_ready       = w_src_ready;
    assign acc_start_in    = (r_state == c_st_start);
    assign acc_valid_input = (r_state == c_st_burst);
    assign acc_x_load      = (r_state == c_st_burst) ? w_rdata : '0;
    assign matrix_idx      = r_matrix_idx;

endmodule : matrix_load_ctrl
`default_nettype wire

// File: tb/tb_matrix_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_load_ctrl
// Purpose  : Self-checking bench for matrix_load_ctrl. An event-level model
//            (bytes accepted, matrices started, burst position, finish
//            scheduling) predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_load_ctrl;

    localparam int DW  = 8;
    localparam int BPM = 32;
    localparam int NM  = 2;
    localparam int TO  = 16;
    localparam int IW  = $clog2(NM) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic          busy, done, error;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_ready;
    logic          acc_start_in, acc_valid_input;
    logic [DW-1:0] acc_x_load;
    logic          acc_finish = 1'b0;
    logic [IW-1:0] matrix_idx;

    always #5 clk = ~clk;

    matrix_load_ctrl #(
        .DATA_W           (DW),
        .BYTES_PER_MATRIX (BPM),
        .NUM_MATRIX       (NM),
        .TIMEOUT_CYC      (TO)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .go              (go),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .src_valid       (src_valid),
        .src_data        (src_data),
        .src_ready       (src_ready),
        .acc_start_in    (acc_start_in),
        .acc_valid_input (acc_valid_input),
        .acc_x_load      (acc_x_load),
        .acc_finish      (acc_finish),
        .matrix_idx      (matrix_idx)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0] job_bytes [NM*BPM];
    int  job_active = 0, waiting_fill = 0, in_wait = 0;
    int  starts = 0, accepted = 0, burst_pos = -1, m_idx = 0;
    int  wait_cnt = 0, fin_at = -1, step_no = 0;
    bit  exp_start = 0, exp_done = 0, exp_err = 0, exp_ready_prev = 0;

    // Stimulus configuration
    int  g_vmode = 0, g_fin_delay = 10, g_spur_at = -1, g_rst_at = -1;
    bit  g_go_hold = 0;

    task automatic step();
        bit rst_p, go_p, fin_p, xfer_p, start_p, done_p, exp_valid, exp_ready;
        logic [7:0] exp_x;
        rst_p   = rst;
        go_p    = go;
        fin_p   = acc_finish;
        xfer_p  = src_valid && exp_ready_prev;
        start_p = exp_start;
        done_p  = exp_done;
        @(posedge clk);
        #1;
        step_no++;
        exp_start = 0;
        exp_done  = 0;
        if (rst_p) begin
            job_active = 0; waiting_fill = 0; in_wait = 0; starts = 0;
            accepted = 0; burst_pos = -1; m_idx = 0; exp_err = 0;
        end else begin
            if (xfer_p) accepted++;
            if (done_p) begin
                job_active = 0;
                m_idx      = 0;
            end else if (!job_active) begin
                if (go_p) begin
                    job_active = 1; waiting_fill = 1; starts = 0;
                    accepted = 0; m_idx = 0; exp_err = 0;
                end
            end else if (start_p) begin
                burst_pos = 0;
            end else if (burst_pos >= 0) begin
                burst_pos++;
                if (burst_pos == BPM) begin
                    burst_pos = -1;
                    in_wait   = 1;
                    wait_cnt  = 0;
                    fin_at    = (g_fin_delay < 0) ? -1 : step_no + g_fin_delay;
                end
            end else if (in_wait) begin
                if (fin_p) begin
                    in_wait = 0;
                    if (m_idx == NM - 1) begin
                        exp_done = 1;
                    end else begin
                        m_idx++;
                        if (accepted == BPM * (starts + 1)) begin
                            exp_start = 1;
                            starts++;
                        end else begin
                            waiting_fill = 1;
                        end
                    end
                end else begin
                    wait_cnt++;
`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
                    if (wait_cnt == TO) begin
                        in_wait = 0; job_active = 0; m_idx = 0; exp_err = 1;
                    end
`endif
                end
            end
            if (waiting_fill && accepted == BPM * (starts + 1)) begin
                exp_start    = 1;
                starts++;
                waiting_fill = 0;
            end
        end

        exp_valid = (burst_pos >= 0);
        exp_x     = exp_valid ? job_bytes[(starts - 1) * BPM + burst_pos] : 8'h00;
        exp_ready = (job_active != 0) && (waiting_fill || (in_wait && starts < NM))
                    && (accepted < BPM * (starts + 1));

        check("busy",      32'(busy),            32'(job_active != 0));
        check("done",      32'(done),            32'(exp_done));
        check("error",     32'(error),           32'(exp_err));
        check("start",     32'(acc_start_in),    32'(exp_start));
        check("valid",     32'(acc_valid_input), 32'(exp_valid));
        check("x_load",    32'(acc_x_load),      32'(exp_x));
        check("src_ready", 32'(src_ready),       32'(exp_ready));
        if (job_active != 0) check("matrix_idx", 32'(matrix_idx), 32'(m_idx));
        exp_ready_prev = exp_ready;

        // Next-cycle drives
        rst = 1'b0;
        if (g_rst_at >= 0 && burst_pos == g_rst_at) begin
            rst      = 1'b1;
            g_rst_at = -1;
        end
        go = (job_active != 0) ? (g_go_hold && !exp_done) : 1'b0;
        acc_finish = (in_wait && step_no == fin_at) ||
                     (g_spur_at >= 0 && burst_pos == g_spur_at);
        if (job_active != 0 && accepted < NM * BPM) begin
            case (g_vmode)
                0:       src_valid = 1'b1;
                1:       src_valid = ~src_valid;
                2:       src_valid = 1'($urandom_range(0, 1));
                default: src_valid = (starts == 0 && waiting_fill) || in_wait;
            endcase
            src_data = job_bytes[accepted];
        end else begin
            src_valid = 1'b0;
            src_data  = '0;
        end
    endtask

    task automatic run_job(input int vmode, input int fdel, input bit hold,
                           input int spur, input int rst_at, input bit seq);
        for (int i = 0; i < NM * BPM; i++) job_bytes[i] = seq ? 8'(i) : 8'($urandom);
        g_vmode = vmode; g_fin_delay = fdel; g_go_hold = hold;
        g_spur_at = spur; g_rst_at = rst_at;
        go = 1'b1;
        step();
        for (int n = 0; n < 3000 && job_active != 0; n++) step();
        check("job_ends", 32'(job_active), 32'd0);
        go = 1'b0;
        for (int n = 0; n < 3; n++) step();
    endtask

    initial begin
        rst = 1'b1;
        step();
        rst = 1'b1;
        step();
        step();
        // Basic job: sequential bytes, back-to-back source, finish after 10
        run_job(0, 10, 1'b0, -1, -1, 1'b1);
        // Bursty source toggling each cycle
        run_job(1, 7, 1'b0, -1, -1, 1'b0);
        // Prefetch: matrix 1 arrives entirely during WAIT_FIN
        run_job(3, 40, 1'b0, -1, -1, 1'b0);
        // go held while busy and a spurious finish mid-burst
        run_job(2, 5, 1'b1, 5, -1, 1'b0);
        // Reset at byte 12 of the first burst, then a fresh job
        run_job(0, 3, 1'b0, -1, 12, 1'b0);
        run_job(0, 0, 1'b0, -1, -1, 1'b1);
`ifdef MATRIX_LOAD_CTRL_TIMEOUT_EN
        // Watchdog: finish never arrives, next go clears error
        run_job(0, -1, 1'b0, -1, -1, 1'b0);
        run_job(2, 4, 1'b0, -1, -1, 1'b0);
`endif
        for (int k = 0; k < 4; k++) begin
            run_job(2, int'($urandom_range(0, 20)), 1'b0, -1, -1, 1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_matrix_load_ctrl
`default_nettype wire
